bram_log_reader: RTL

- Drains a timestamped event log from a BRAM array and streams each entry out on a valid/ready interface.
- Log entry layout in BRAM: timestamp in bits [31:0], metadata in bits [32 +: LOG_DATA_BITW], zero-padded to a 32-bit multiple.
- Drives the read port of the log BRAM as a master with a fixed 1-cycle read latency.
- Uses a 2-entry output buffer so throughput is one entry per cycle while Ready_SI is held high.

---
 rtl/bram_log_reader_if.sv | 41 ++++
 rtl/bram_log_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_log_reader_if.sv
// -----------------------------------------------------------------------------
// bram_log_reader_if
// Bundles every non-clock, non-reset signal of bram_log_reader:
//   control  : Start_SI, NumEntries_DI (in)  / Busy_SO, Done_SO (out)
//   BRAM port: BramEn_SO, BramAddr_SO (out)  / BramRdData_DI (in, 1-cycle latency)
//   stream   : Valid_SO, Timestamp_DO, LogData_DO, Last_SO (out) / Ready_SI (in)
// Modport master is the reader itself; modport slave is its environment
// (BRAM, downstream sink and the controlling agent).
// -----------------------------------------------------------------------------
interface bram_log_reader_if #(
  parameter int LOG_DATA_BITW   = 32,
  parameter int NUM_LOG_ENTRIES = 16384
);
  localparam int LOG_ENTRY_BITW = ((32 + LOG_DATA_BITW + 31) / 32) * 32;
  localparam int CNT_BITW       = $clog2(NUM_LOG_ENTRIES);

  logic                      Start_SI;
  logic [CNT_BITW:0]         NumEntries_DI;
  logic                      Busy_SO;
  logic                      Done_SO;
  logic                      BramEn_SO;
  logic [CNT_BITW-1:0]       BramAddr_SO;
  logic [LOG_ENTRY_BITW-1:0] BramRdData_DI;
  logic                      Valid_SO;
  logic                      Ready_SI;
  logic [31:0]               Timestamp_DO;
  logic [LOG_DATA_BITW-1:0]  LogData_DO;
  logic                      Last_SO;

  modport master (
    input  Start_SI, NumEntries_DI, BramRdData_DI, Ready_SI,
    output Busy_SO, Done_SO, BramEn_SO, BramAddr_SO,
           Valid_SO, Timestamp_DO, LogData_DO, Last_SO
  );

  modport slave (
    output Start_SI, NumEntries_DI, BramRdData_DI, Ready_SI,
    input  Busy_SO, Done_SO, BramEn_SO, BramAddr_SO,
           Valid_SO, Timestamp_DO, LogData_DO, Last_SO
  );
endinterface

// File: rtl/bram_log_reader.sv
// -----------------------------------------------------------------------------
// bram_log_reader
// Drains entries 0..N-1 of a timestamped event log held in a BRAM and streams
// them out on a valid/ready interface, one entry per cycle while Ready_SI is
// high.
// Ports:
//   Clk_CI  clock
//   Rst_RI  synchronous active-high reset (aborts any pass, drops reads in flight)
//   bus     bram_log_reader_if.master: control, BRAM read port, output stream
// The output stage is a two-deep buffer built as an output register plus a
// skid register, so every stream output comes straight from a flop.
// -----------------------------------------------------------------------------
module bram_log_reader #(
  parameter int LOG_DATA_BITW   = 32,
  parameter int NUM_LOG_ENTRIES = 16384
) (
  input  logic              Clk_CI,
  input  logic              Rst_RI,
  bram_log_reader_if.master bus
);
  localparam int LOG_ENTRY_BITW = ((32 + LOG_DATA_BITW + 31) / 32) * 32;
  localparam int CNT_BITW       = $clog2(NUM_LOG_ENTRIES);
  localparam int CW             = CNT_BITW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READING = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             n_q, n_d;
  logic [CW-1:0]             rd_cnt_q, rd_cnt_d;
  logic                      inflight_q, inflight_d;
  logic                      inflight_last_q, inflight_last_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      out_vld_q, out_vld_d;
  logic [31:0]               out_ts_q, out_ts_d;
  logic [LOG_DATA_BITW-1:0]  out_data_q, out_data_d;
  logic                      out_last_q, out_last_d;
  logic                      skid_vld_q, skid_vld_d;
  logic [31:0]               skid_ts_q, skid_ts_d;
  logic [LOG_DATA_BITW-1:0]  skid_data_q, skid_data_d;
  logic                      skid_last_q, skid_last_d;

  logic [LOG_ENTRY_BITW-1:0] rd_word_s;
  logic [CW-1:0]             n_clamp_s;
  logic [CW-1:0]             n_last_s;
  logic [1:0]                occ_next_s;
  logic                      pop_s;
  logic                      push_s;
  logic                      issue_s;
  logic                      is_last_rd_s;

  assign rd_word_s    = bus.BramRdData_DI;
  assign n_clamp_s    = (bus.NumEntries_DI > CW'(NUM_LOG_ENTRIES)) ?
                        CW'(NUM_LOG_ENTRIES) : bus.NumEntries_DI;
  assign n_last_s     = n_q - CW'(1);
  assign pop_s        = out_vld_q & bus.Ready_SI;
  assign push_s       = inflight_q;
  // Occupancy the buffer will have next cycle: the returning read is pushed
  // and the current head may be popped. Counting the pop here is what keeps
  // one read per cycle going while the sink accepts every cycle.
  assign occ_next_s   = 2'({1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, inflight_q} - {1'b0, pop_s});
  assign issue_s      = (state_q == ST_READING) && (occ_next_s < 2'd2);
  assign is_last_rd_s = (rd_cnt_q == n_last_s);

  // Control FSM: pass length, read counter, read issue and Done generation
  always_comb begin
    state_d         = state_q;
    n_d             = n_q;
    rd_cnt_d        = rd_cnt_q;
    done_d          = 1'b0;
    inflight_d      = issue_s;
    inflight_last_d = issue_s & is_last_rd_s;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start_SI) begin
          n_d      = n_clamp_s;
          rd_cnt_d = CW'(0);
          if (n_clamp_s == CW'(0)) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_READING;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READING: begin
        if (issue_s) begin
          rd_cnt_d = rd_cnt_q + CW'(1);
          if (is_last_rd_s) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_READING;
          end
        end else begin
          state_d = ST_READING;
        end
      end
      ST_DRAIN: begin
        // Done is a flop, so raise it the cycle before the pipeline empties;
        // it then coincides with the DRAIN->IDLE transition cycle.
        done_d = (out_vld_q | skid_vld_q | inflight_q) & (occ_next_s == 2'd0);
        if (!out_vld_q && !skid_vld_q && !inflight_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Output buffer: head register feeds the stream, skid register absorbs one
  // extra entry while the sink stalls
  always_comb begin
    out_vld_d   = out_vld_q;
    out_ts_d    = out_ts_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    skid_vld_d  = skid_vld_q;
    skid_ts_d   = skid_ts_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    if (skid_vld_q) begin
      if (pop_s) begin
        out_vld_d  = 1'b1;
        out_ts_d   = skid_ts_q;
        out_data_d = skid_data_q;
        out_last_d = skid_last_q;
        if (push_s) begin
          skid_ts_d   = rd_word_s[31:0];
          skid_data_d = rd_word_s[32 +: LOG_DATA_BITW];
          skid_last_d = inflight_last_q;
        end else begin
          skid_vld_d  = 1'b0;
          skid_last_d = 1'b0;
        end
      end else begin
        skid_vld_d = 1'b1;
      end
    end else if (!out_vld_q || pop_s) begin
      if (push_s) begin
        out_vld_d  = 1'b1;
        out_ts_d   = rd_word_s[31:0];
        out_data_d = rd_word_s[32 +: LOG_DATA_BITW];
        out_last_d = inflight_last_q;
      end else begin
        out_vld_d  = 1'b0;
        out_last_d = 1'b0;
      end
    end else begin
      if (push_s) begin
        skid_vld_d  = 1'b1;
        skid_ts_d   = rd_word_s[31:0];
        skid_data_d = rd_word_s[32 +: LOG_DATA_BITW];
        skid_last_d = inflight_last_q;
      end else begin
        skid_vld_d = 1'b0;
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q         <= ST_IDLE;
      n_q             <= CW'(0);
      rd_cnt_q        <= CW'(0);
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      out_vld_q       <= 1'b0;
      out_ts_q        <= 32'd0;
      out_data_q      <= LOG_DATA_BITW'(0);
      out_last_q      <= 1'b0;
      skid_vld_q      <= 1'b0;
      skid_ts_q       <= 32'd0;
      skid_data_q     <= LOG_DATA_BITW'(0);
      skid_last_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      n_q             <= n_d;
      rd_cnt_q        <= rd_cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      out_vld_q       <= out_vld_d;
      out_ts_q        <= out_ts_d;
      out_data_q      <= out_data_d;
      out_last_q      <= out_last_d;
      skid_vld_q      <= skid_vld_d;
      skid_ts_q       <= skid_ts_d;
      skid_data_q     <= skid_data_d;
      skid_last_q     <= skid_last_d;
    end
  end

  // BramEn_SO must see this cycle's pop to sustain full throughput, so it is
  // the only output decoded combinationally (from flops and Ready_SI).
  assign bus.BramEn_SO    = issue_s;
  assign bus.BramAddr_SO  = rd_cnt_q[CNT_BITW-1:0];
  assign bus.Busy_SO      = busy_q;
  assign bus.Done_SO      = done_q;
  assign bus.Valid_SO     = out_vld_q;
  assign bus.Timestamp_DO = out_ts_q;
  assign bus.LogData_DO   = out_data_q;
  assign bus.Last_SO      = out_last_q;

  bram_log_reader_chk u_chk (
    .clk_i      (Clk_CI),
    .rst_i      (Rst_RI),
    .push_i     (push_s),
    .pop_i      (pop_s),
    .out_vld_i  (out_vld_q),
    .skid_vld_i (skid_vld_q)
  );
endmodule

// -----------------------------------------------------------------------------
// bram_log_reader_chk
// Simulation properties of the output buffer: no push into a full buffer and
// a valid head never disappears without a handshake.
// -----------------------------------------------------------------------------
module bram_log_reader_chk (
  input logic clk_i,
  input logic rst_i,
  input logic push_i,
  input logic pop_i,
  input logic out_vld_i,
  input logic skid_vld_i
);
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && out_vld_i && skid_vld_i && !pop_i));

  a_valid_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_vld_i && !pop_i) |=> out_vld_i);
endmodule
